// File: rtl/scsa_vl_recovery.sv
// Variable-latency wrapper around a speculative carry-select adder.
// The operand pair is registered, and the speculative and exact sums are
// both formed from those registers. In approximate mode the speculative sum
// is returned after one cycle. In exact mode a detected misspeculation costs
// one extra recovery cycle, and the exact sum is returned instead.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | empty, ready for an operand pair
// EVAL  | operands registered; speculative sum and error are evaluated
// FIX   | misspeculation in exact mode; exact sum is loaded next edge
// DONE  | result presented; held until the consumer takes it
module scsa_vl_recovery #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Cin_i,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S_o,
    output logic             Co_o,
    output logic             err_o,
    output logic             fixed_o,
    output logic [CNTW-1:0]  err_cnt,
    input  logic             cnt_clr
);

    localparam int NB = WIDTH / BLK;

    typedef enum logic [1:0] {IDLE, EVAL, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             approx_q;

    logic [NB-1:0]    spec_c;
    logic [NB-1:0]    mis;
    logic [WIDTH-1:0] spec_s;
    logic             spec_co;
    logic [WIDTH:0]   sum_full;
    logic             err;
    logic             accept;

    // Exact reference sum; its per-bit sums also reveal the true block carries
    assign sum_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = k * BLK;

        if (k == 0) begin : g_first
            assign spec_c[0] = cin_q;
            assign mis[0]    = 1'b0;
        end else begin : g_rest
            // Speculated carry-in is the generate of the block below (carry-in 0)
            assign spec_c[k] = ({1'b0, a_q[LO-BLK +: BLK]} + {1'b0, b_q[LO-BLK +: BLK]})
                               > {1'b0, {BLK{1'b1}}};
            // True carry into bit LO recovered as a ^ b ^ sum
            assign mis[k]    = spec_c[k] ^ (a_q[LO] ^ b_q[LO] ^ sum_full[LO]);
        end

        if (k == NB - 1) begin : g_top
            assign {spec_co, spec_s[LO +: BLK]} = {1'b0, a_q[LO +: BLK]} + {1'b0, b_q[LO +: BLK]}
                                                + {{BLK{1'b0}}, spec_c[k]};
        end else begin : g_low
            assign spec_s[LO +: BLK] = a_q[LO +: BLK] + b_q[LO +: BLK]
                                     + {{(BLK-1){1'b0}}, spec_c[k]};
        end
    end

    assign err      = |mis;
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Sequencing FSM with registered operands and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            approx_q  <= 1'b0;
            out_valid <= 1'b0;
            S_o       <= '0;
            Co_o      <= 1'b0;
            err_o     <= 1'b0;
            fixed_o   <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= A_i;
                b_q      <= B_i;
                cin_q    <= Cin_i;
                approx_q <= approx_en;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= EVAL;
                end
                EVAL: begin
                    if (!err || approx_q) begin
                        S_o       <= spec_s;
                        Co_o      <= spec_co;
                        err_o     <= err;
                        fixed_o   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state     <= FIX;
                    end
                end
                FIX: begin
                    S_o       <= sum_full[WIDTH-1:0];
                    Co_o      <= sum_full[WIDTH];
                    err_o     <= 1'b1;
                    fixed_o   <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? EVAL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating misspeculation counter; clear takes priority over a count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if ((state == EVAL) && err && (err_cnt != {CNTW{1'b1}})) begin
            err_cnt <= err_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_scsa_vl_recovery.sv
// Directed bench for scsa_vl_recovery. A default instance (CNTW=16) and a
// narrow-counter instance (CNTW=4) share every input, so the counter of the
// narrow instance can be driven into saturation.
module tb_scsa_vl_recovery;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        approx;
    logic        out_ready;
    logic        cnt_clr;

    logic        ir, ov, co, errw, fixw;
    logic [15:0] s;
    logic [15:0] cnt;
    logic        ir4, ov4, co4, err4, fix4;
    logic [15:0] s4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_err = 0;
    int m_cnt = 0;
    int m_cnt4 = 0;

    scsa_vl_recovery dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir),
        .A_i(a), .B_i(b), .Cin_i(cin), .approx_en(approx),
        .out_valid(ov), .out_ready(out_ready), .S_o(s), .Co_o(co),
        .err_o(errw), .fixed_o(fixw), .err_cnt(cnt), .cnt_clr(cnt_clr)
    );

    scsa_vl_recovery #(.WIDTH(16), .BLK(4), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .A_i(a), .B_i(b), .Cin_i(cin), .approx_en(approx),
        .out_valid(ov4), .out_ready(out_ready), .S_o(s4), .Co_o(co4),
        .err_o(err4), .fixed_o(fix4), .err_cnt(cnt4), .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation with out_ready held high; result latency is counted in
    // clock edges after the acceptance edge.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic tap, input logic tclr,
                          input int e_lat, input logic [15:0] e_s,
                          input logic e_co, input logic e_err, input logic e_fix);
        int lat;
        a = ta; b = tb_; cin = tc; approx = tap;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(ir), 32'd1);
        check({tag, "_in_ready4"}, 32'(ir4), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt_clr = tclr;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            if (ov) begin
                lat = i;
                break;
            end
        end
        if (tclr) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (e_err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_S"}, 32'(s), 32'(e_s));
        check({tag, "_Co"}, 32'(co), 32'(e_co));
        check({tag, "_err"}, 32'(errw), 32'(e_err));
        check({tag, "_fixed"}, 32'(fixw), 32'(e_fix));
        check({tag, "_err_cnt"}, 32'(cnt), 32'(m_cnt));
        check({tag, "_ov4"}, 32'(ov4), 32'd1);
        check({tag, "_S4"}, 32'({co4, err4, fix4, s4}), 32'({e_co, e_err, e_fix, e_s}));
        check({tag, "_err_cnt4"}, 32'(cnt4), 32'(m_cnt4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        approx = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_outputs", 32'({co, errw, fixw, s}), 32'd0);
        check("rst_err_cnt", 32'(cnt), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(ir), 32'd1);

        run_op("nocarry", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1, 16'h2345, 1'b0, 1'b0, 1'b0);
        run_op("apx_mis", 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("exa_mis", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 2, 16'h0100, 1'b0, 1'b1, 1'b1);
        run_op("apx_rip", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1, 16'hFF00, 1'b0, 1'b1, 1'b0);
        run_op("exa_rip", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_op("cin_mis", 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 16'h0010, 1'b0, 1'b1, 1'b1);

        // Backpressure: drain to IDLE, then hold the result for 3 cycles while
        // a second operand pair waits on the input.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; approx = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 16'h0F0F; b = 16'h0101;
        check("bp_eval_in_ready", 32'(ir), 32'd0);
        @(posedge clk); #1;
        check("bp_first_valid", 32'(ov), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(ov), 32'd1);
            check("bp_hold_S", 32'(s), 32'h2345);
            check("bp_hold_in_ready", 32'(ir), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid_drop", 32'(ov), 32'd0);
        @(posedge clk); #1;
        check("b2b_valid", 32'(ov), 32'd1);
        check("b2b_S", 32'(s), 32'h1010);
        check("b2b_flags", 32'({co, errw, fixw}), 32'd0);
        check("b2b_err_cnt", 32'(cnt), 32'(m_cnt));

        // Reset asserted while the exact-mode recovery cycle is in progress
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("fix_no_valid", 32'(ov), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({ov, co, errw, fixw, s}), 32'd0);
        check("midrst_err_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        check("midrst_hold", 32'(ov), 32'd0);
        #2 rst_n = 1'b1;
        m_cnt = 0; m_cnt4 = 0;
        @(posedge clk); #1;
        check("midrst_after_valid", 32'(ov), 32'd0);
        check("midrst_after_ready", 32'(ir), 32'd1);

        // 20 misspeculated operations: the narrow counter stops at 0xF
        for (int i = 0; i < 20; i++)
            run_op("sat", 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("sat_cnt16", 32'(cnt), 32'd20);
        check("sat_cnt4", 32'(cnt4), 32'hF);

        run_op("clr_coinc", 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("clr_cnt16_zero", 32'(cnt), 32'd0);
        run_op("after_clr", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b1, 1'b1, 1'b1);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scsa_vl_recovery.md
Name: scsa_vl_recovery

Overview:
- Variable-latency, error-recovering wrapper stage that sits downstream of the speculative carry-select sum blocks.
- Registers one operand pair and forms the speculative carry-select result: per-block sums with speculated carry-ins.
- Detects carry misspeculation.
- Approximate mode: returns the speculative result. Exact mode: spends one recovery cycle and returns the corrected sum.
- Valid/ready on both sides; also keeps a saturating misspeculation counter for error-rate characterisation.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLK.
- BLK, 4, speculation block width; NB = WIDTH/BLK blocks.
- CNTW, 16, width of the error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept operands.
- A_i  in  WIDTH  operand A.
- B_i  in  WIDTH  operand B.
- Cin_i  in  1  carry into block 0.
- approx_en  in  1  1 = return speculative result; sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- S_o  out  WIDTH  sum.
- Co_o  out  1  carry out of the top block.
- err_o  out  1  misspeculation detected for this result.
- fixed_o  out  1  result came through the recovery cycle.
- err_cnt  out  CNTW  saturating count of misspeculated operations.
- cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - out_valid, S_o, Co_o, err_o, fixed_o, err_cnt all = 0.
  - Operand registers = 0.
  - in_ready is 1 after reset release.
- Speculation, from the registered operands:
  - Block k covers bits [k*BLK +: BLK].
  - spec_c[0] = Cin_i (registered). For k≥1, spec_c[k] = carry-out of block k-1 computed with carry-in 0 (block generate).
  - Spec sum block k = (A_k + B_k + spec_c[k]) mod 2^BLK.
  - Spec Co = carry-out of block NB-1 with carry-in spec_c[NB-1].
  - True carries true_c[k] come from the full-width add A + B + Cin.
  - err = OR over k≥1 of (spec_c[k] != true_c[k]).
- FSM states: IDLE, EVAL, FIX, DONE.
- in_ready is 1 in IDLE, or in DONE when out_ready=1.
  - Acceptance = in_valid & in_ready.
  - Acceptance loads A_i, B_i, Cin_i, approx_en and moves to EVAL.
  - This permits back-to-back operation; peak throughput is 1 result per 2 cycles.
- EVAL (exactly 1 cycle). On the next edge:
  - If err=0 or approx_en=1:
    - S_o/Co_o = speculative result (identical to exact when err=0).
    - err_o = err, fixed_o = 0, out_valid = 1.
    - Go to DONE.
  - Otherwise:
    - Go to FIX; out_valid stays 0.
- FIX (exactly 1 cycle). On the next edge:
  - S_o/Co_o = exact sum.
  - err_o = 1, fixed_o = 1, out_valid = 1.
  - Go to DONE.
- DONE: outputs are held stable while out_ready=0.
  - out_ready=1 and in_valid=1: accept new operands, out_valid drops to 0, go to EVAL.
  - out_ready=1 and in_valid=0: out_valid drops to 0, go to IDLE.
- Latency from the acceptance edge to out_valid:
  - 1 cycle when no error or approx mode.
  - 2 cycles when exact mode with error.
- err_cnt:
  - Increments by 1 on the EVAL exit edge when err=1, in both modes.
  - Saturates at 2^CNTW-1.
  - cnt_clr=1 forces 0 on the next edge; if clear coincides with an increment, clear wins.
- Reset asserted mid-operation (EVAL/FIX/DONE): the operation is dropped with no output; err_cnt = 0.
- in_valid while in EVAL or FIX: ignored; in_ready = 0, no operand load.

Test Plan:
- No-carry add: A=0x1234, B=0x1111, Cin=0, approx_en=0 -> out_valid 1 cycle after acceptance; S_o=0x2345, Co=0, err=0, fixed=0; err_cnt unchanged.
- Approx misspeculation: A=0x00FF, B=0x0001, approx_en=1 -> 1-cycle latency; S_o=0x0000, Co=0, err=1, fixed=0; err_cnt +1.
- Exact recovery: same operands with approx_en=0 -> 2-cycle latency; S_o=0x0100, Co=0, err=1, fixed=1.
- Full ripple: A=0xFFFF, B=0x0001, Cin=0:
  - approx -> S_o=0xFF00, Co=0, err=1.
  - exact -> S_o=0x0000, Co=1, fixed=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> new operands accepted in the same cycle; next result after 1 cycle.
- Reset and counter:
  - Assert rst_n=0 during FIX -> no out_valid, all outputs 0.
  - Preload err_cnt near saturation (CNTW=4), run 20 erroring ops -> err_cnt stops at 0xF.
  - cnt_clr coincident with an erroring op -> err_cnt=0.
